systolic_drain: RTL and testbench

SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

---
 rtl/systolic_drain.sv | 120 ++++++++++++
 tb/tb_systolic_drain.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
// Drains a ROWS x COLS systolic array: snapshots every PE accumulator once all are valid,
// streams them row-major over a valid/ready port, then pulses a one-cycle array clear.
`ifndef SYSTOLIC_RESULT_WIDTH
`define SYSTOLIC_RESULT_WIDTH 32
`endif

module systolic_drain #(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4,
  parameter int unsigned ACC_WIDTH = `SYSTOLIC_RESULT_WIDTH,
  localparam int unsigned ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned COL_W    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ROWS*COLS*ACC_WIDTH-1:0] acc_value_flat,
  input  logic [ROWS*COLS-1:0]           acc_valid_flat,
  output logic signed [ACC_WIDTH-1:0]    out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ROW_W-1:0]               out_row,
  output logic [COL_W-1:0]               out_col,
  output logic                           out_last,
  output logic                           array_clear,
  output logic                           busy,
  output logic [15:0]                    tile_count
);

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    CLEAR
  } state_t;

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic signed [ACC_WIDTH-1:0] buffer [N];

  logic             all_valid;
  logic             capture;
  logic [IDX_W-1:0] idx_nxt;

  assign all_valid = &acc_valid_flat;
  assign capture   = (state == IDLE) && all_valid;
  assign idx_nxt   = idx + 1'b1;

  // Snapshot buffer: only written on the capture edge, so later PE activity cannot leak in.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned i = 0; i < N; i++) begin
        buffer[i] <= signed'(acc_value_flat[i*ACC_WIDTH +: ACC_WIDTH]);
      end
    end
  end

  // Control FSM with registered outputs; the offered element only changes on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      out_row     <= '0;
      out_col     <= '0;
      array_clear <= 1'b0;
      busy        <= 1'b0;
      tile_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (all_valid) begin
            state     <= STREAM;
            idx       <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_data  <= signed'(acc_value_flat[ACC_WIDTH-1:0]);
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= (N == 1);
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (out_last) begin
              state       <= CLEAR;
              out_valid   <= 1'b0;
              out_last    <= 1'b0;
              array_clear <= 1'b1;
              tile_count  <= tile_count + 16'd1;
            end else begin
              idx      <= idx_nxt;
              out_data <= buffer[idx_nxt];
              out_last <= (idx_nxt == IDX_W'(N - 1));
              // Row-major walk kept as counters to avoid a divider.
              if (out_col == COL_W'(COLS - 1)) begin
                out_col <= '0;
                out_row <= out_row + 1'b1;
              end else begin
                out_col <= out_col + 1'b1;
              end
            end
          end
        end
        CLEAR: begin
          state       <= IDLE;
          array_clear <= 1'b0;
          busy        <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain (2x2, 32-bit): directed table, corner sequences,
// and random tiles checked against a queue-based row-major element model.
module tb_systolic_drain;

  localparam int unsigned ROWS = 2;
  localparam int unsigned COLS = 2;
  localparam int unsigned W    = 32;
  localparam int unsigned N    = ROWS * COLS;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*W-1:0]   acc_value_flat;
  logic [N-1:0]     acc_valid_flat;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [0:0]       out_row;
  logic [0:0]       out_col;
  logic             out_last;
  logic             array_clear;
  logic             busy;
  logic [15:0]      tile_count;

  systolic_drain #(.ROWS(ROWS), .COLS(COLS), .ACC_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .acc_value_flat(acc_value_flat), .acc_valid_flat(acc_valid_flat),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .array_clear(array_clear), .busy(busy), .tile_count(tile_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          row;
    int          col;
    bit          last;
  } elem_t;

  typedef struct {
    logic [N*W-1:0] vals;
    logic [15:0]    pat;
    bit             scramble;
    int             exp_tc;
  } vec_t;

  elem_t exp_q[$];
  elem_t mon_e;
  int    gap_q[$];
  vec_t  vecs[3];

  int n_chk = 0, n_pass = 0;
  int n_xfer = 0, n_clear = 0, exp_clears = 0;
  int tiles_started = 0, tiles_done = 0;
  int cyc = 0, last_cyc = -1;

  logic [31:0] pd;
  logic [0:0]  pr, pc;
  logic        pl;
  bit          prev_stall = 1'b0, prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  // Model: a captured tile yields its elements in row-major order, last flag on the final one.
  task automatic push_tile(input logic [N*W-1:0] v);
    elem_t e;
    for (int i = 0; i < N; i++) begin
      e.data = v[i*W +: W];
      e.row  = i / COLS;
      e.col  = i % COLS;
      e.last = (i == N - 1);
      exp_q.push_back(e);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      chk("busy_vs_state", 32'(busy), 32'(out_valid | array_clear));
      if (array_clear) begin
        n_clear++;
        chk("clear_without_valid", 32'(out_valid), 32'd0);
      end
      if (out_valid) begin
        if (!prev_valid) begin
          tiles_started++;
          if (last_cyc >= 0) gap_q.push_back(cyc - last_cyc);
        end
        if (prev_stall) begin
          chk("stall_data", out_data, pd);
          chk("stall_row", 32'(out_row), 32'(pr));
          chk("stall_col", 32'(out_col), 32'(pc));
          chk("stall_last", 32'(out_last), 32'(pl));
        end
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_valid: got data %0h, expected no element", out_data);
        end else begin
          mon_e = exp_q[0];
          chk("elem_data", out_data, mon_e.data);
          chk("elem_row", 32'(out_row), 32'(mon_e.row));
          chk("elem_col", 32'(out_col), 32'(mon_e.col));
          chk("elem_last", 32'(out_last), 32'(mon_e.last));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_xfer++;
            if (out_last) last_cyc = cyc;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      pr = out_row;
      pc = out_col;
      pl = out_last;
      prev_valid = out_valid;
    end
  end

  // Runs one tile from IDLE through CLEAR and back to IDLE.
  task automatic run_tile(input logic [N*W-1:0] vals, input logic [15:0] pat, input bit scramble);
    int start;
    int k;
    push_tile(vals);
    acc_value_flat = vals;
    acc_valid_flat = '1;
    out_ready      = pat[0];
    step();
    chk("first_valid", 32'(out_valid), 32'd1);
    acc_valid_flat = '0;
    if (scramble) acc_value_flat = {$urandom(), $urandom(), $urandom(), $urandom()};
    start = n_xfer;
    k = 0;
    while ((n_xfer - start) < N && k < 200) begin
      step();
      k++;
      out_ready = pat[k % 16];
    end
    chk("tile_xfers", 32'(n_xfer - start), 32'(N));
    chk("clear_pulse", 32'(array_clear), 32'd1);
    chk("clear_valid", 32'(out_valid), 32'd0);
    chk("clear_busy", 32'(busy), 32'd1);
    tiles_done++;
    exp_clears++;
    out_ready = 1'b0;
    step();
    chk("idle_clear", 32'(array_clear), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("tile_count", 32'(tile_count), 32'(tiles_done));
  endtask

  initial begin
    int base;
    int k;
    logic [N*W-1:0] v;

    vecs[0] = '{pack4(32'd5, 32'hFFFF_FFFD, 32'd7, 32'h7FFF_FFFF), 16'hFFFF, 1'b0, 1};
    vecs[1] = '{pack4(32'd5, 32'hFFFF_FFFD, 32'd7, 32'h7FFF_FFFF), 16'h4A52, 1'b0, 2};
    vecs[2] = '{pack4(32'h8000_0000, 32'd1, 32'hDEAD_BEEF, 32'd0), 16'hB5B5, 1'b1, 3};

    rst = 1'b1;
    acc_value_flat = '0;
    acc_valid_flat = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_clear", 32'(array_clear), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tile_count", 32'(tile_count), 32'd0);
    chk("rst_data", out_data, 32'd0);
    rst = 1'b0;
    step();

    // Directed table: plain drain, stalled drain, drain with PE values changing after capture.
    for (int i = 0; i < 3; i++) begin
      run_tile(vecs[i].vals, vecs[i].pat, vecs[i].scramble);
      chk("vec_tile_count", 32'(tile_count), 32'(vecs[i].exp_tc));
      chk("vec_clears", 32'(n_clear), 32'(exp_clears));
    end

    // Partial valid must never start a tile.
    acc_valid_flat = 4'b0111;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("partial_busy", 32'(busy), 32'd0);
      chk("partial_valid", 32'(out_valid), 32'd0);
    end
    run_tile(pack4(32'd11, 32'd22, 32'd33, 32'd44), 16'hFFFF, 1'b0);

    // Reset after two transfers discards the tile.
    v = pack4(32'd100, 32'd200, 32'd300, 32'd400);
    push_tile(v);
    acc_value_flat = v;
    acc_valid_flat = '1;
    out_ready = 1'b1;
    base = n_xfer;
    step();
    acc_valid_flat = '0;
    step();
    step();
    chk("pre_reset_xfers", 32'(n_xfer - base), 32'd2);
    rst = 1'b1;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    exp_q.delete();
    tiles_done = 0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_clear", 32'(array_clear), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tile_count", 32'(tile_count), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_row", 32'(out_row), 32'd0);
    chk("mid_rst_col", 32'(out_col), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("mid_rst_no_clear", 32'(n_clear), 32'(exp_clears));
    chk("mid_rst_no_resume", 32'(out_valid), 32'd0);

    // Three back-to-back tiles with valid held high.
    last_cyc = -1;
    gap_q.delete();
    base = tiles_started;
    v = pack4(32'd9, 32'hFFFF_FFFF, 32'd123456, 32'h7FFF_FFFF);
    for (int t = 0; t < 3; t++) push_tile(v);
    acc_value_flat = v;
    acc_valid_flat = '1;
    out_ready = 1'b1;
    k = 0;
    while ((tile_count != 16'd3 || busy) && k < 100) begin
      step();
      k++;
      if (tiles_started - base >= 3) acc_valid_flat = '0;
    end
    acc_valid_flat = '0;
    tiles_done = 3;
    exp_clears += 3;
    chk("b2b_tile_count", 32'(tile_count), 32'd3);
    chk("b2b_gap_count", 32'(gap_q.size()), 32'd2);
    foreach (gap_q[i]) chk("b2b_gap", 32'(gap_q[i]), 32'd3);
    chk("b2b_clears", 32'(n_clear), 32'(exp_clears));
    out_ready = 1'b0;
    step();

    // Random tiles with random backpressure and post-capture PE churn.
    for (int i = 0; i < 6; i++) begin
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_tile(v, 16'($urandom()) | 16'h0001, 1'b1);
    end
    chk("rand_clears", 32'(n_clear), 32'(exp_clears));
    chk("model_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
